stopwatch_bcd_n: RTL and testbench

//  Parametrised BCD stopwatch/timer core: DIGITS-digit up/down counter, run/pause/clear controller FSM
//  and time-multiplexed digit scan. Single clock domain; count and scan rates come from tick strobes.

---
 rtl/stopwatch_bcd_n_if.sv | 28 ++
 rtl/stopwatch_bcd_n.sv | 149 ++++++++++++++
 tb/tb_stopwatch_bcd_n.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_bcd_n_if.sv
// Stopwatch core signal bundle: tick strobes, buttons, mode/preset in; count and display scan out.
interface stopwatch_bcd_n_if #(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2
);
  logic                     cnt_tick;
  logic                     scan_tick;
  logic                     P;
  logic                     CLR;
  logic [1:0]               sel;
  logic [4*LOAD_DIGITS-1:0] load;
  logic [4*DIGITS-1:0]      count;
  logic [3:0]               digit;
  logic [DIGITS-1:0]        an;
  logic                     dp;
  logic                     running;
  logic                     done;

  modport master (
    output cnt_tick, scan_tick, P, CLR, sel, load,
    input  count, digit, an, dp, running, done
  );

  modport slave (
    input  cnt_tick, scan_tick, P, CLR, sel, load,
    output count, digit, an, dp, running, done
  );
endinterface

// File: rtl/stopwatch_bcd_n.sv
// BCD stopwatch/timer core: up/down BCD counter, run/pause/clear FSM and digit scan.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_CLEAR | mode and preset latched from sel/load every cycle
//  S_IDLE  | paused, count held, rising P starts counting
//  S_RUN   | count steps on cnt_tick, rising P pauses, terminal -> DONE
//  S_DONE  | count held at terminal, only CLR leaves
module stopwatch_bcd_n #(
  parameter int DIGITS      = 4,
  parameter int LOAD_DIGITS = 2,
  parameter int DP_POS      = 2
) (
  input logic              c_clk,
  input logic              R_n,
  stopwatch_bcd_n_if.slave bus
);

  localparam int IDXW = $clog2(DIGITS);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                p_d_q;
  logic                pe;
  logic                count_down;
  logic [4*DIGITS-1:0] terminal;

  function automatic logic [4*DIGITS-1:0] bcd_step(input logic [4*DIGITS-1:0] v,
                                                   input logic down);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (!down) begin
          if (d == 4'd9) d = 4'd0;
          else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) d = 4'd9;
          else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Load nibbles above 9 are clamped so the counter never holds a non-BCD digit.
  function automatic logic [4*DIGITS-1:0] preset(input logic [1:0] m,
                                                 input logic [4*LOAD_DIGITS-1:0] ld);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          n;
    r = '0;
    case (m)
      2'd2: r = ALL_NINES;
      2'd1, 2'd3: begin
        for (int j = 0; j < LOAD_DIGITS; j++) begin
          n = ld[4*j +: 4];
          if (n > 4'd9) n = 4'd9;
          r[4*(DIGITS-LOAD_DIGITS+j) +: 4] = n;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign pe         = bus.P & ~p_d_q;
  assign count_down = (mode_q == 2'd2) || (mode_q == 2'd3);
  assign terminal   = count_down ? '0 : ALL_NINES;

  // State, counter, mode, P history and scan index registers.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= S_CLEAR;
      count_q <= '0;
      mode_q  <= 2'd0;
      idx_q   <= '0;
      p_d_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      p_d_q   <= bus.P;
    end
  end

  // Next state: CLR beats everything, terminal beats a pause request in RUN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    if (bus.scan_tick) idx_d = (idx_q == IDXW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
    case (state_q)
      S_CLEAR: begin
        mode_d  = bus.sel;
        count_d = preset(bus.sel, bus.load);
        if (!bus.CLR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.CLR) state_d = S_CLEAR;
        else if (pe) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.CLR) state_d = S_CLEAR;
        else if (count_q == terminal) state_d = S_DONE;
        else begin
          if (bus.cnt_tick) count_d = bcd_step(count_q, count_down);
          if (pe) state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.CLR) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Display scan decode, purely combinational from index and count.
  always_comb begin
    bus.an = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) bus.an[i] = 1'b0;
    end
  end

  assign bus.digit   = count_q[4*idx_q +: 4];
  assign bus.dp      = (idx_q != IDXW'(DP_POS));
  assign bus.count   = count_q;
  assign bus.running = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_stopwatch_bcd_n.sv
// Bench for stopwatch_bcd_n: directed vector table, corner-case sequences and random run vs a value model.
module tb_stopwatch_bcd_n;

  localparam int DIG = 4;
  localparam int LD  = 2;
  localparam int DPP = 2;

  localparam int M_CLEAR = 0;
  localparam int M_IDLE  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic c_clk = 1'b0;
  logic R_n   = 1'b0;

  stopwatch_bcd_n_if #(.DIGITS(DIG), .LOAD_DIGITS(LD)) sw_if ();

  stopwatch_bcd_n #(.DIGITS(DIG), .LOAD_DIGITS(LD), .DP_POS(DPP)) dut (
    .c_clk (c_clk),
    .R_n   (R_n),
    .bus   (sw_if)
  );

  always #5 c_clk = ~c_clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: count as a plain integer value
  int m_st, m_cnt, m_mode, m_idx;
  bit m_pd;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIG-1:0] to_bcd(input int v);
    logic [4*DIG-1:0] r;
    for (int i = 0; i < DIG; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int min9(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  function automatic int preset_val(input int s, input logic [4*LD-1:0] ld);
    int hi = 0;
    if (s == 0) return 0;
    if (s == 2) return pow10(DIG) - 1;
    for (int j = LD - 1; j >= 0; j--) hi = hi * 10 + min9(ld[4*j +: 4]);
    return hi * pow10(DIG - LD);
  endfunction

  function automatic int term_val(input int mode);
    return (mode >= 2) ? 0 : pow10(DIG) - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_CLEAR; m_cnt = 0; m_mode = 0; m_idx = 0; m_pd = 0;
  endtask

  task automatic model_step();
    bit pe;
    pe = sw_if.P && !m_pd;
    case (m_st)
      M_CLEAR: begin
        m_mode = int'(sw_if.sel);
        m_cnt  = preset_val(m_mode, sw_if.load);
        if (!sw_if.CLR) m_st = M_IDLE;
      end
      M_IDLE: begin
        if (sw_if.CLR) m_st = M_CLEAR;
        else if (pe) m_st = M_RUN;
      end
      M_RUN: begin
        if (sw_if.CLR) m_st = M_CLEAR;
        else if (m_cnt == term_val(m_mode)) m_st = M_DONE;
        else begin
          if (sw_if.cnt_tick) m_cnt = (m_mode >= 2) ? m_cnt - 1 : m_cnt + 1;
          if (pe) m_st = M_IDLE;
        end
      end
      default: if (sw_if.CLR) m_st = M_CLEAR;
    endcase
    m_pd = sw_if.P;
    if (sw_if.scan_tick) m_idx = (m_idx + 1) % DIG;
  endtask

  task automatic compare_model();
    logic [DIG-1:0] e_an;
    e_an = ~(DIG'(1) << m_idx);
    check("model count",   32'(sw_if.count),   32'(to_bcd(m_cnt)));
    check("model digit",   32'(sw_if.digit),   32'((m_cnt / pow10(m_idx)) % 10));
    check("model an",      32'(sw_if.an),      32'(e_an));
    check("model dp",      32'(sw_if.dp),      32'(m_idx != DPP));
    check("model running", 32'(sw_if.running), 32'(m_st == M_RUN));
    check("model done",    32'(sw_if.done),    32'(m_st == M_DONE));
  endtask

  task automatic tick();
    @(posedge c_clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input logic p, input logic clr, input logic ct, input logic st,
                       input logic [1:0] s, input logic [7:0] ld);
    sw_if.P = p; sw_if.CLR = clr; sw_if.cnt_tick = ct; sw_if.scan_tick = st;
    sw_if.sel = s; sw_if.load = ld;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " count"},   32'(sw_if.count),   32'h0);
    check({tag, " an"},      32'(sw_if.an),      32'b1110);
    check({tag, " digit"},   32'(sw_if.digit),   32'h0);
    check({tag, " dp"},      32'(sw_if.dp),      32'(DPP != 0));
    check({tag, " running"}, 32'(sw_if.running), 32'h0);
    check({tag, " done"},    32'(sw_if.done),    32'h0);
  endtask

  task automatic do_reset();
    R_n = 1'b0;
    drive(0, 0, 0, 0, 2'd0, 8'h00);
    repeat (2) @(posedge c_clk);
    #1;
    check_reset_outputs("reset");
    model_reset();
    R_n = 1'b1;
  endtask

  typedef struct {
    logic        p, clr, ct;
    logic [1:0]  sel;
    logic [7:0]  load;
    logic [15:0] cnt;
    logic        run, dn;
  } vec_t;

  vec_t vt[21];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            p  clr ct sel   load   count     run dn
    vt[0]  = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h10, 16'h1000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 2'd3, 8'h10, 16'h1000, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 2'd3, 8'h10, 16'h1000, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h10, 16'h0999, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h10, 16'h0998, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h10, 16'h0998, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h10, 16'h0998, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h10, 16'h0998, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'h10, 16'h0998, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h10, 16'h9999, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h10, 16'h9999, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h10, 16'h9998, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'h10, 16'h9998, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 16'h0000, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b1};
    vt[17] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b1};
    vt[18] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 16'h0000, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 2'd1, 8'hA7, 16'h9700, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 2'd1, 8'hA7, 16'h9700, 1'b0, 1'b0};

    // reset values are visible while R_n is still low, before any clock edge
    drive(0, 0, 0, 0, 2'd0, 8'h00);
    #2;
    check_reset_outputs("async reset");

    // directed vector table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].p, vt[i].clr, vt[i].ct, 1'b0, vt[i].sel, vt[i].load);
      tick();
      check($sformatf("vec%0d count", i),   32'(sw_if.count),   32'(vt[i].cnt));
      check($sformatf("vec%0d running", i), 32'(sw_if.running), 32'(vt[i].run));
      check($sformatf("vec%0d done", i),    32'(sw_if.done),    32'(vt[i].dn));
    end

    // up from zero, 12 steps
    do_reset();
    drive(0, 1, 0, 0, 2'd0, 8'h00); tick();
    drive(0, 0, 0, 0, 2'd0, 8'h00); tick();
    drive(1, 0, 0, 0, 2'd0, 8'h00); tick();
    drive(0, 0, 1, 0, 2'd2, 8'h00);
    repeat (12) tick();
    check("up12 count",   32'(sw_if.count),   32'h0012);
    check("up12 running", 32'(sw_if.running), 32'h1);
    check("up12 done",    32'(sw_if.done),    32'h0);

    // reset asserted between edges while running
    #2;
    R_n = 1'b0;
    #1;
    check_reset_outputs("midrun reset");
    repeat (2) @(posedge c_clk);
    #1;
    model_reset();
    R_n = 1'b1;

    // up from load 0x99 to terminal, then hold
    drive(0, 1, 0, 0, 2'd1, 8'h99); tick();
    check("load99 preset", 32'(sw_if.count), 32'h9900);
    drive(0, 0, 0, 0, 2'd1, 8'h99); tick();
    drive(1, 0, 0, 0, 2'd1, 8'h99); tick();
    drive(0, 0, 1, 0, 2'd1, 8'h99);
    repeat (99) tick();
    check("term count",   32'(sw_if.count), 32'h9999);
    check("term done",    32'(sw_if.done),  32'h0);
    tick();
    check("term done1",   32'(sw_if.done),    32'h1);
    check("term running", 32'(sw_if.running), 32'h0);
    repeat (3) tick();
    check("term hold",    32'(sw_if.count), 32'h9999);

    // scan sequence from index 0
    do_reset();
    begin
      logic [3:0] exp_an [4];
      exp_an[0] = 4'b1101; exp_an[1] = 4'b1011; exp_an[2] = 4'b0111; exp_an[3] = 4'b1110;
      drive(0, 0, 0, 1, 2'd0, 8'h00);
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("scan%0d an", k), 32'(sw_if.an), 32'(exp_an[k]));
        check($sformatf("scan%0d dp", k), 32'(sw_if.dp), 32'(exp_an[k] != 4'b1011));
      end
    end

    // random run against the value model
    do_reset();
    begin
      logic [7:0] ld;
      logic       p;
      p = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) p = ~p;
        case ($urandom_range(0, 5))
          0: ld = 8'h99;
          1: ld = 8'h98;
          2: ld = 8'h00;
          3: ld = 8'h01;
          default: ld = 8'($urandom);
        endcase
        drive(p, ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0), 2'($urandom), ld);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
